wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Writeback arbiter: the producer side of the register file write port.
- Merges the single-cycle ALU result stream and the multi-cycle load/store (LS) result stream into the one regfile write port: `rf_we_n` (active-low), `rf_rd`, `rf_wd`.
- Buffers LS results in a small FIFO.
- Reports per-register pending writes so the decode stage can stall dependent reads.

Parameters:
- DEPTH, 2, LS FIFO entries (power of two, ≥2).
- STARVE_MAX, 4, consecutive cycles a non-empty FIFO may go undrained before `alu_stall` is raised.

Ports:
- clk  in  1  clock, posedge active.
- rst_n  in  1  reset, asynchronous, active-low.
- alu_valid  in  1  ALU result valid this cycle (no ready; never back-pressured).
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- alu_stall  out  1  registered; core must not assert `alu_valid` next cycle.
- ls_valid  in  1  LS result valid.
- ls_ready  out  1  = FIFO not full (combinational from occupancy).
- ls_rd  in  5  LS destination register.
- ls_data  in  32  LS result.
- rf_we_n  out  1  regfile write enable, active-low, registered.
- rf_rd  out  5  regfile write address, registered.
- rf_wd  out  32  regfile write data, registered.
- pending_mask  out  32  bit i = live FIFO entry targets xi; bit 0 always 0.
- err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (async, `rst_n` low):
  - `rf_we_n`=1, `rf_rd`=0, `rf_wd`=0.
  - FIFO empty, `ls_ready`=1, `pending_mask`=0, `alu_stall`=0, `err`=0, starve counter=0.
  - Reset mid-operation discards all FIFO contents; no write is issued.
- LS enqueue:
  - Accept when `ls_valid` && `ls_ready` at a posedge.
  - `ls_rd`==0: the handshake completes but nothing is stored.
  - `ls_valid` && !`ls_ready`: LS holds; no error.
- Per-cycle selection, exactly one candidate registered into `rf_*`:
  - `alu_valid` && `alu_rd`!=0 → ALU write. Latency 1: inputs at edge N give `rf_we_n`=0 after edge N.
  - Otherwise, FIFO head valid and live → pop and write. Minimum LS latency is 2 cycles: enqueue at edge N, write visible after edge N+1.
  - Otherwise → `rf_we_n`=1; `rf_rd`/`rf_wd` hold their previous values.
  - A killed (dead) head is popped silently in any cycle the ALU does not own the port, with `rf_we_n`=1.
  - `alu_valid` with `alu_rd`==0 counts as no ALU write.
- Same-rd ordering (ALU is always younger than queued LS):
  - An ALU write to rd=r kills every live FIFO entry with rd=r in the same cycle.
  - Same-cycle LS enqueue and ALU write with equal rd: the LS entry is treated as older and is not stored.
  - Two LS entries to the same rd are both written, in FIFO order.
- `pending_mask`: OR of the one-hot rd of all live FIFO entries. Updates the same edge as enqueue/pop/kill.
- Starvation control:
  - Counter increments each cycle the FIFO holds a live head that is not drained; clears on any pop; saturates.
  - Counter reaching STARVE_MAX → `alu_stall`=1 for exactly one cycle.
  - During that cycle the FIFO head is written.
  - `alu_valid` while `alu_stall`=1: ALU still wins and `err` is set (sticky until reset).
- Simultaneous enqueue and pop when full: pop frees a slot in the same cycle, but `ls_ready` reflects the pre-edge occupancy (no same-cycle pass-through).
- Pointers wrap modulo DEPTH. A full/empty distinction bit is required.

Test Plan:
- Reset release, idle 5 cycles → `rf_we_n`=1, `ls_ready`=1, `pending_mask`=0, `err`=0 throughout.
- ALU r5=0x11112222 at edge 1 → after edge 1: `rf_we_n`=0, `rf_rd`=5, `rf_wd`=0x11112222; after edge 2: `rf_we_n`=1.
- LS r7=0xDEADBEEF at edge 1, no ALU traffic → `pending_mask`=0x80 after edge 1; write r7 after edge 2; mask back to 0.
- Two LS writes (DEPTH=2) with `alu_valid` every cycle on r1:
  - `ls_ready`=0.
  - After 4 undrained cycles `alu_stall`=1 for one cycle; LS head written that cycle.
  - Next cycle the ALU holds.
- LS r9=0xAAAA queued, then ALU r9=0xBBBB → only r9=0xBBBB written; r9 bit cleared; dead entry popped silently.
- Corner cases:
  - `alu_valid` during `alu_stall` → `err`=1, stays 1 until `rst_n` low.
  - `rst_n` low with 2 entries queued → FIFO empty, no write afterwards.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges the ALU and load/store result streams onto the single regfile write port.
// Ports:
//   clk, rst_n                  clock (posedge), asynchronous active-low reset
//   alu_valid/alu_rd/alu_data   single-cycle ALU result, never back-pressured
//   alu_stall                   registered; core must keep alu_valid low while it is high
//   ls_valid/ls_ready/ls_rd/ls_data  load/store result handshake into the LS FIFO
//   rf_we_n/rf_rd/rf_wd         registered regfile write port (we active-low)
//   pending_mask                one bit per register targeted by a live queued LS result
//   err                         sticky: alu_valid seen while alu_stall was high
module wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic        ls_valid,
  output logic        ls_ready,
  input  logic [4:0]  ls_rd,
  input  logic [31:0] ls_data,
  output logic        rf_we_n,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wd,
  output logic [31:0] pending_mask,
  output logic        err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CMAX = CW'(STARVE_MAX);
  logic [AW:0]        wp_q, wp_d, rp_q, rp_d;
  logic [DEPTH-1:0]   live_q, live_d;
  logic [4:0]         rd_q [DEPTH];
  logic [4:0]         rd_d [DEPTH];
  logic [31:0]        dat_q [DEPTH];
  logic [31:0]        dat_d [DEPTH];
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               stall_q, stall_d, err_q, err_d, we_n_q, we_n_d;
  logic [4:0]         rf_rd_q, rf_rd_d;
  logic [31:0]        rf_wd_q, rf_wd_d;
  logic               empty, full, alu_wr, head_live, pop, push, ls_wr;
  logic [AW-1:0]      hi, ti;

  always_comb begin
    empty     = wp_q == rp_q;
    full      = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    hi        = rp_q[AW-1:0];
    ti        = wp_q[AW-1:0];
    alu_wr    = alu_valid && alu_rd != 5'd0;
    head_live = !empty && live_q[hi];
    // any head (live or killed) leaves the FIFO whenever the ALU does not own the port
    pop       = !empty && !alu_wr;
    ls_wr     = pop && head_live;
    // rd==0 results and results overwritten by a same-cycle younger ALU write are dropped
    push      = ls_valid && !full && ls_rd != 5'd0 && !(alu_wr && alu_rd == ls_rd);
    live_d    = live_q;
    rd_d      = rd_q;
    dat_d     = dat_q;
    for (int i = 0; i < DEPTH; i++)
      if (alu_wr && rd_q[i] == alu_rd) live_d[i] = 1'b0;
    if (pop) live_d[hi] = 1'b0;
    if (push) begin
      live_d[ti] = 1'b1;
      rd_d[ti]   = ls_rd;
      dat_d[ti]  = ls_data;
    end
    wp_d    = wp_q + {{AW{1'b0}}, push};
    rp_d    = rp_q + {{AW{1'b0}}, pop};
    we_n_d  = !(alu_wr || ls_wr);
    rf_rd_d = alu_wr ? alu_rd : ls_wr ? rd_q[hi] : rf_rd_q;
    rf_wd_d = alu_wr ? alu_data : ls_wr ? dat_q[hi] : rf_wd_q;
    cnt_d   = (pop || !head_live) ? '0 : (cnt_q == CMAX) ? cnt_q : cnt_q + 1'b1;
    // never two stall cycles in a row, so a compliant core always gets the slot back
    stall_d = cnt_d == CMAX && !stall_q;
    err_d   = err_q || (alu_valid && stall_q);
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (live_q[i]) pending_mask[rd_q[i]] = 1'b1;
    pending_mask[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      live_q  <= '0;
      rd_q    <= '{default: '0};
      dat_q   <= '{default: '0};
      cnt_q   <= '0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
      we_n_q  <= 1'b1;
      rf_rd_q <= '0;
      rf_wd_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      live_q  <= live_d;
      rd_q    <= rd_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      err_q   <= err_d;
      we_n_q  <= we_n_d;
      rf_rd_q <= rf_rd_d;
      rf_wd_q <= rf_wd_d;
    end
  end

  assign ls_ready  = !full;
  assign alu_stall = stall_q;
  assign err       = err_q;
  assign rf_we_n   = we_n_q;
  assign rf_rd     = rf_rd_q;
  assign rf_wd     = rf_wd_q;
endmodule
